boss_ctrl: RTL
==============

Name: boss_ctrl

Overview:
Parametrised next-generation boss core. Combines the frame-tick divider, multi-player aggro targeting, boss movement, HP and damage accounting, and a fight-phase state machine into one block. Supports N players with a remote HP-sync channel, and adds an enrage phase with a separate speed. Drives the position and HP inputs of the boss renderer and the collision logic in the game top.

Parameters:
CLK_HZ, 65_000_000, system clock frequency
FPS, 60, frame tick rate; TICKS = CLK_HZ/FPS (integer division)
NUM_PLAYERS, 2, number of player channels (1..4)
HP_W, 7, HP width
MAX_HP, 100, HP loaded at fight start
ENRAGE_HP, 30, HP at or below which the boss enrages
DMG, 2, HP removed per accepted hit
SPEED, 2, px per frame tick in CHASE
SPEED_ENRAGE, 4, px per frame tick in ENRAGE
START_X, 512, spawn x
X_MIN, 0, leftmost boss_x
X_MAX, 918, rightmost boss_x
GROUND_Y, 600, constant boss_y

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
game_active  in  2  fight runs only when value is 2'd1
game_start  in  1  one-cycle pulse; (re)starts the fight
player_x  in  12*NUM_PLAYERS  packed x positions; player i occupies bits [12i+11:12i]
player_aggro  in  4*NUM_PLAYERS  packed aggro values; player i occupies bits [4i+3:4i]
player_valid  in  NUM_PLAYERS  channel i present
hit  in  NUM_PLAYERS  one-cycle hit pulse per player
hp_sync_valid  in  1  remote HP value valid this cycle
hp_sync_value  in  HP_W  remote boss HP
frame_tick  out  1  one-cycle pulse every TICKS clocks
boss_x  out  12  boss x position
boss_y  out  12  constant GROUND_Y
boss_hp  out  HP_W  current HP
boss_phase  out  2  0 IDLE, 1 CHASE, 2 ENRAGE, 3 DEAD
target_idx  out  2  index of the currently chased player

Behaviour:
- Reset is sampled on the clk edge with rst==0. Reset values: tick counter 0, frame_tick 0, boss_x START_X, boss_hp MAX_HP, boss_phase IDLE, target_idx 0.
- Tick divider:
  - Counter runs 0..TICKS-1 regardless of game_active.
  - frame_tick is registered: it is 1 for the single cycle after the counter equals TICKS-1; the counter wraps to 0 on that same edge.
- FSM:
  - IDLE → CHASE on game_start.
  - CHASE → ENRAGE when boss_hp <= ENRAGE_HP and boss_hp != 0.
  - CHASE or ENRAGE → DEAD when boss_hp == 0.
  - DEAD → CHASE on game_start.
  - The transition is evaluated on the registered boss_hp, so the phase changes one cycle after the HP update.
  - game_start in any state reloads boss_hp=MAX_HP, boss_x=START_X, target_idx=0 and enters CHASE. This has priority over hits, sync and movement in the same cycle.
- Freeze: when game_active != 1, boss_x, boss_hp, boss_phase and target_idx hold. game_start is still honoured.
- Targeting (on frame_tick, in CHASE or ENRAGE):
  - target_idx = the valid player with the largest aggro; ties go to the lowest index.
  - If no player is valid, target_idx holds.
- Movement (same frame_tick, uses the newly selected target's x):
  - step = SPEED in CHASE, SPEED_ENRAGE in ENRAGE.
  - If |target_x - boss_x| <= step, boss_x = target_x; otherwise boss_x moves by step toward target_x.
  - Result is clamped to [X_MIN, X_MAX].
  - Difference is computed in 13-bit signed arithmetic.
  - No movement in IDLE or DEAD.
- Damage (every cycle, in CHASE or ENRAGE only):
  - n = popcount(hit & player_valid); dmg = n*DMG.
  - boss_hp = (boss_hp > dmg) ? boss_hp - dmg : 0, i.e. saturating at 0, no wrap.
- HP sync: if hp_sync_valid is high in CHASE or ENRAGE, boss_hp = min(post-damage local HP, hp_sync_value). HP never increases via sync.
- Hits and sync in IDLE or DEAD are ignored.
- boss_y = GROUND_Y constant.
- Reset asserted mid-fight returns all state to reset values on the next edge, including the tick counter.

Test Plan:
1. CLK_HZ=600, FPS=60 → frame_tick high exactly 1 cycle in 10; first pulse 10 cycles after reset release; held low while rst=0.
2. game_start; P0 x=700 aggro=3, P1 x=100 aggro=5, both valid; boss_x=512 → on next tick target_idx=1, boss_x=510; after 206 ticks boss_x=100 and holds there.
3. Tie: aggro both 5 → target_idx=0. Clear P0 valid → target_idx=1. Clear both valid → target_idx holds.
4. In CHASE, hp=32, hit=2'b11 → hp=28, boss_phase=ENRAGE next cycle, step becomes 4. Then hp=3 with hit=2'b11 → hp=0, phase DEAD, boss_x frozen, further hits ignored.
5. hp=50, hp_sync_valid with value 40 plus one hit → hp=40; sync value 60 → hp stays 50.
6. game_active=2 mid-fight → hp/x frozen despite hits. game_start with a simultaneous hit → hp=100, x=512, CHASE. rst=0 mid-move → all outputs at reset values.

Source files
------------

// File: rtl/boss_ctrl.sv
// Boss core: frame-tick divider, aggro targeting, movement, HP/damage accounting and fight-phase FSM.
// All boss state freezes unless i_game_active == 1; i_game_start always restarts the fight.
module boss_ctrl #(
    parameter int CLK_HZ       = 65_000_000,
    parameter int FPS          = 60,
    parameter int NUM_PLAYERS  = 2,
    parameter int HP_W         = 7,
    parameter int MAX_HP       = 100,
    parameter int ENRAGE_HP    = 30,
    parameter int DMG          = 2,
    parameter int SPEED        = 2,
    parameter int SPEED_ENRAGE = 4,
    parameter int START_X      = 512,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 918,
    parameter int GROUND_Y     = 600
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [1:0]                i_game_active,
    input  logic                      i_game_start,
    input  logic [12*NUM_PLAYERS-1:0] i_player_x,
    input  logic [4*NUM_PLAYERS-1:0]  i_player_aggro,
    input  logic [NUM_PLAYERS-1:0]    i_player_valid,
    input  logic [NUM_PLAYERS-1:0]    i_hit,
    input  logic                      i_hp_sync_valid,
    input  logic [HP_W-1:0]           i_hp_sync_value,
    output logic                      o_frame_tick,
    output logic [11:0]               o_boss_x,
    output logic [11:0]               o_boss_y,
    output logic [HP_W-1:0]           o_boss_hp,
    output logic [1:0]                o_boss_phase,
    output logic [1:0]                o_target_idx
);

    localparam int TICKS = CLK_HZ / FPS;
    localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int DMG_W = HP_W + 8;

    localparam logic [CNT_W-1:0]    TICK_LAST = CNT_W'(TICKS - 1);
    localparam logic [HP_W-1:0]     HP_FULL   = HP_W'(MAX_HP);
    localparam logic [HP_W-1:0]     HP_ENR    = HP_W'(ENRAGE_HP);
    localparam logic [11:0]         X_START   = 12'(START_X);
    localparam logic [11:0]         X_LO12    = 12'(X_MIN);
    localparam logic [11:0]         X_HI12    = 12'(X_MAX);
    localparam logic signed [13:0]  X_LO      = 14'(X_MIN);
    localparam logic signed [13:0]  X_HI      = 14'(X_MAX);
    localparam logic [12:0]         STEP_CH   = 13'(SPEED);
    localparam logic [12:0]         STEP_EN   = 13'(SPEED_ENRAGE);
    localparam logic [DMG_W-1:0]    DMG_PER   = DMG_W'(DMG);

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_CHASE  = 2'd1,
        PH_ENRAGE = 2'd2,
        PH_DEAD   = 2'd3
    } phase_t;

    function automatic logic [2:0] count_hits(input logic [NUM_PLAYERS-1:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic [11:0]      r_x;
    logic [HP_W-1:0]  r_hp;
    logic [1:0]       r_tgt;
    phase_t           r_phase;

    phase_t            w_phase_next;
    logic              w_run;
    logic              w_any_valid;
    logic [1:0]        w_best_idx;
    logic [3:0]        w_best_aggro;
    logic [1:0]        w_new_tgt;
    logic [11:0]       w_tgt_x;
    logic [12:0]       w_step;
    logic signed [12:0] w_diff;
    logic [12:0]       w_abs;
    logic signed [13:0] w_cand;
    logic [11:0]       w_next_x;
    logic [2:0]        w_nhits;
    logic [DMG_W-1:0]  w_dmg;
    logic [HP_W-1:0]   w_hp_dmg;
    logic [HP_W-1:0]   w_hp_next;

    // Frame-tick divider: free-running, pulse registered one cycle after the last count
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == TICK_LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
        end
    end

    assign w_run = (i_game_active == 2'd1) && ((r_phase == PH_CHASE) || (r_phase == PH_ENRAGE));

    // Target selection: highest aggro among valid players, strict compare keeps the lowest index on ties
    always_comb begin
        w_any_valid  = 1'b0;
        w_best_idx   = 2'd0;
        w_best_aggro = 4'd0;
        w_tgt_x      = 12'd0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (i_player_valid[i] && (!w_any_valid || (i_player_aggro[4*i +: 4] > w_best_aggro))) begin
                w_any_valid  = 1'b1;
                w_best_idx   = 2'(i);
                w_best_aggro = i_player_aggro[4*i +: 4];
            end else begin
                w_any_valid  = w_any_valid;
            end
        end
        w_new_tgt = w_any_valid ? w_best_idx : r_tgt;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (2'(i) == w_new_tgt) begin
                w_tgt_x = i_player_x[12*i +: 12];
            end else begin
                w_tgt_x = w_tgt_x;
            end
        end
    end

    // Movement step toward the new target, snapping when within one step, then clamped to the arena
    always_comb begin
        w_step = (r_phase == PH_ENRAGE) ? STEP_EN : STEP_CH;
        w_diff = $signed({1'b0, w_tgt_x}) - $signed({1'b0, r_x});
        w_abs  = w_diff[12] ? 13'(-w_diff) : 13'(w_diff);
        if (w_abs <= w_step) begin
            w_cand = $signed({2'b00, w_tgt_x});
        end else if (!w_diff[12]) begin
            w_cand = $signed({2'b00, r_x}) + $signed({1'b0, w_step});
        end else begin
            w_cand = $signed({2'b00, r_x}) - $signed({1'b0, w_step});
        end
        if (w_cand < X_LO) begin
            w_next_x = X_LO12;
        end else if (w_cand > X_HI) begin
            w_next_x = X_HI12;
        end else begin
            w_next_x = w_cand[11:0];
        end
    end

    // Saturating damage from valid hitters, then remote sync may only lower the result
    always_comb begin
        w_nhits = count_hits(i_hit & i_player_valid);
        w_dmg   = DMG_W'(w_nhits) * DMG_PER;
        if (DMG_W'(r_hp) > w_dmg) begin
            w_hp_dmg = r_hp - w_dmg[HP_W-1:0];
        end else begin
            w_hp_dmg = '0;
        end
        if (i_hp_sync_valid && (i_hp_sync_value < w_hp_dmg)) begin
            w_hp_next = i_hp_sync_value;
        end else begin
            w_hp_next = w_hp_dmg;
        end
    end

    // Boss position, HP and target registers
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_x   <= X_START;
            r_hp  <= HP_FULL;
            r_tgt <= 2'd0;
        end else if (i_game_start) begin
            r_x   <= X_START;
            r_hp  <= HP_FULL;
            r_tgt <= 2'd0;
        end else if (w_run) begin
            r_hp <= w_hp_next;
            if (r_tick) begin
                r_x   <= w_next_x;
                r_tgt <= w_new_tgt;
            end else begin
                r_x   <= r_x;
                r_tgt <= r_tgt;
            end
        end else begin
            r_x   <= r_x;
            r_hp  <= r_hp;
            r_tgt <= r_tgt;
        end
    end

    // Phase register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_phase <= PH_IDLE;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // Phase transitions look at the registered HP, so they lag the HP update by one cycle
    always_comb begin
        w_phase_next = r_phase;
        if (i_game_start) begin
            w_phase_next = PH_CHASE;
        end else if (i_game_active != 2'd1) begin
            w_phase_next = r_phase;
        end else begin
            case (r_phase)
                PH_IDLE: begin
                    w_phase_next = PH_IDLE;
                end
                PH_CHASE: begin
                    if (r_hp == '0) begin
                        w_phase_next = PH_DEAD;
                    end else if (r_hp <= HP_ENR) begin
                        w_phase_next = PH_ENRAGE;
                    end else begin
                        w_phase_next = PH_CHASE;
                    end
                end
                PH_ENRAGE: begin
                    if (r_hp == '0) begin
                        w_phase_next = PH_DEAD;
                    end else begin
                        w_phase_next = PH_ENRAGE;
                    end
                end
                PH_DEAD: begin
                    w_phase_next = PH_DEAD;
                end
                default: begin
                    w_phase_next = PH_IDLE;
                end
            endcase
        end
    end

    assign o_frame_tick = r_tick;
    assign o_boss_x     = r_x;
    assign o_boss_y     = 12'(GROUND_Y);
    assign o_boss_hp    = r_hp;
    assign o_boss_phase = r_phase;
    assign o_target_idx = r_tgt;

endmodule
